// File: rtl/addseq_pkg.sv
// ============================================================================
// Module      : addseq_pkg
// Description : State encoding and index-width helper for multiword_add_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice-index width; a single-slice build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_add_slice.sv
// ============================================================================
// Module      : ripple_add_slice
// Description : Combinational SIZE-bit ripple-carry adder from per-bit gates.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_add_slice #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci,
  output logic [SIZE-1:0] s,
  output logic            co
);

  logic [SIZE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (p & c[i]);
  end

  assign co = c[SIZE];

endmodule

`default_nettype wire

// File: rtl/multiword_add_seq.sv
// ============================================================================
// Module      : multiword_add_seq
// Description : Wide adder that reuses one SIZE-bit ripple slice over WORDS
//               cycles, LS slice first. Define ADDSEQ_SUB_EN for subtraction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiword_add_seq
  import addseq_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE*WORDS-1:0] op_a,
  input  logic [SIZE*WORDS-1:0] op_b,
  input  logic                  c_in,
`ifdef ADDSEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE*WORDS-1:0] sum,
  output logic                  c_out,
  output logic                  busy
);

  localparam int W  = SIZE * WORDS;
  localparam int IW = idx_width(WORDS);

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [SIZE-1:0] slice_a;
  logic [SIZE-1:0] slice_b;
  logic [SIZE-1:0] slice_s;
  logic            slice_co;
  logic            accept;
  logic            last;
  logic [W-1:0]    b_eff;
  logic            carry_init;

`ifdef ADDSEQ_SUB_EN
  // Subtraction as a + ~b + 1; c_out then reads as "no borrow".
  assign b_eff      = sub ? ~op_b : op_b;
  assign carry_init = sub ? 1'b1  : c_in;
`else
  assign b_eff      = op_b;
  assign carry_init = c_in;
`endif

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign last      = (idx == IW'(WORDS - 1));

  assign slice_a = a_reg[int'(idx)*SIZE +: SIZE];
  assign slice_b = b_reg[int'(idx)*SIZE +: SIZE];

  ripple_add_slice #(
    .SIZE (SIZE)
  ) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= op_a;
        b_reg <= b_eff;
        carry <= carry_init;
        idx   <= '0;
      end
      if (state == ST_RUN) begin
        sum[int'(idx)*SIZE +: SIZE] <= slice_s;
        carry                       <= slice_co;
        if (last) begin
          c_out <= slice_co;
          idx   <= '0;
        end else begin
          idx   <= idx + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
// ============================================================================
// Module      : tb_multiword_add_seq
// Description : Directed bench for multiword_add_seq (4x4 and 1x8 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
  logic [15:0] op_a, op_b, sum;
  logic        sub;

  logic        in1_valid, in1_ready, c1_in, out1_valid, out1_ready, c1_out, busy1;
  logic [7:0]  op1_a, op1_b, sum1;
  logic        sub1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.SIZE(4), .WORDS(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .c_in      (c_in),
`ifdef ADDSEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  multiword_add_seq #(.SIZE(8), .WORDS(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .op_a      (op1_a),
    .op_b      (op1_b),
    .c_in      (c1_in),
`ifdef ADDSEQ_SUB_EN
    .sub       (sub1),
`endif
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .sum       (sum1),
    .c_out     (c1_out),
    .busy      (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure accept-to-out_valid latency, check, drain.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s,
                        input logic [15:0] exp_sum, input logic exp_co);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; c_in = ci; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_c_out"}, 32'(c_out), 32'(exp_co));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    in_valid = 1'b0; op_a = '0; op_b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in1_valid = 1'b0; op1_a = '0; op1_b = '0; c1_in = 1'b0; sub1 = 1'b0; out1_ready = 1'b0;
    tick();
    tick();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("add_7_8",    16'h0007, 16'h0008, 1'b0, 1'b0, 16'h000F, 1'b0);
    run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("add_9_b_ci", 16'h0009, 16'h000B, 1'b1, 1'b0, 16'h0015, 1'b0);
    run_op("add_ci_only",16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("add_msb",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Backpressure: result must be held and new operands dropped.
    op_a = 16'h1234; op_b = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      op_a = 16'hAAAA; op_b = 16'h5555; c_in = 1'b1; in_valid = 1'b1;
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h5555);
      check("bp_c_out", 32'(c_out), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_no_queued_op", 32'(busy), 32'd0);

    // Reset while RUN is at slice index 2.
    op_a = 16'hFFFF; op_b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_c_out", 32'(c_out), 32'd0);
    rst = 1'b0;
    #1;
    run_op("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);

`ifdef ADDSEQ_SUB_EN
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    sub = 1'b0;
`endif

    // Single-slice build: one RUN cycle.
    check("w1_in_ready", 32'(in1_ready), 32'd1);
    op1_a = 8'hF0; op1_b = 8'h20; c1_in = 1'b0; in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    lat = 0;
    while (!out1_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("w1_latency", 32'(lat), 32'd1);
    check("w1_sum", 32'(sum1), 32'h10);
    check("w1_c_out", 32'(c1_out), 32'd1);
    out1_ready = 1'b1;
    tick();
    out1_ready = 1'b0;
    check("w1_drained", 32'(out1_valid), 32'd0);
    check("w1_in_ready_again", 32'(in1_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
